// File: rtl/ex_flag_stage_if.sv
// EX -> EX/MEM boundary bundle: the execute-stage result and control coming in,
// and the registered result, committed flags and branch decision going out.
interface ex_flag_stage_if #(
    parameter int DW = 16
);
    logic          ex_valid;
    logic [3:0]    ex_op;
    logic [DW-1:0] ex_result;
    logic          ex_ovfl;
    logic          stall;
    logic          flush;
    logic [2:0]    br_ccc;

    logic          mem_valid;
    logic [DW-1:0] mem_result;
    logic          flag_n;
    logic          flag_z;
    logic          flag_v;
    logic          br_taken;

    // Producer side: the EX stage / pipeline control driving this block.
    modport master (
        output ex_valid, ex_op, ex_result, ex_ovfl, stall, flush, br_ccc,
        input  mem_valid, mem_result, flag_n, flag_z, flag_v, br_taken
    );

    // The flag stage itself.
    modport slave (
        input  ex_valid, ex_op, ex_result, ex_ovfl, stall, flush, br_ccc,
        output mem_valid, mem_result, flag_n, flag_z, flag_v, br_taken
    );
endinterface

// File: rtl/ex_flag_stage.sv
// EX/MEM boundary register plus the architectural N/Z/V flag register.
// Branch condition for the instruction in decode is evaluated combinationally,
// optionally seeing the flags the current EX instruction is about to write.
module ex_flag_stage #(
    parameter int DW          = 16,
    parameter bit FLAG_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    ex_flag_stage_if.slave    bus
);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;

    logic          r_mem_valid;
    logic [DW-1:0] r_mem_result;
    logic          r_flag_n;
    logic          r_flag_z;
    logic          r_flag_v;

    logic          w_we;
    logic          w_wr_nv;
    logic          w_wr_z;
    logic          w_new_n;
    logic          w_new_z;
    logic          w_new_v;
    logic          w_byp_nv;
    logic          w_byp_z;
    logic          w_nn;
    logic          w_nz;
    logic          w_nv;
    logic          w_br_taken;

    // A stalled or flushed instruction never commits anything.
    assign w_we    = bus.ex_valid & ~bus.stall & ~bus.flush;

    // Arithmetic ops own all three flags; logic/shift ops only touch Z.
    assign w_wr_nv = (bus.ex_op == OP_ADD) || (bus.ex_op == OP_SUB);
    assign w_wr_z  = w_wr_nv ||
                     (bus.ex_op == OP_XOR) || (bus.ex_op == OP_SLL) ||
                     (bus.ex_op == OP_SRA) || (bus.ex_op == OP_ROR);

    // Z is taken from the saturated result, so a saturated overflow is never zero.
    assign w_new_n = bus.ex_result[DW-1];
    assign w_new_z = (bus.ex_result == '0);
    assign w_new_v = bus.ex_ovfl;

    // Flag register: only the flags owned by the EX opcode change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_n <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_v <= 1'b0;
        end else if (w_we) begin
            if (w_wr_nv) begin
                r_flag_n <= w_new_n;
                r_flag_v <= w_new_v;
            end
            if (w_wr_z) begin
                r_flag_z <= w_new_z;
            end
        end
    end

    // EX/MEM register: flush kills valid, stall freezes, bubbles keep the old result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid  <= 1'b0;
            r_mem_result <= '0;
        end else if (bus.flush) begin
            r_mem_valid  <= 1'b0;
        end else if (!bus.stall) begin
            r_mem_valid <= bus.ex_valid;
            if (bus.ex_valid) begin
                r_mem_result <= bus.ex_result;
            end
        end
    end

    // Forward the in-flight flag values so a dependent branch need not wait a cycle.
    assign w_byp_nv = FLAG_BYPASS && w_we && w_wr_nv;
    assign w_byp_z  = FLAG_BYPASS && w_we && w_wr_z;
    assign w_nn     = w_byp_nv ? w_new_n : r_flag_n;
    assign w_nv     = w_byp_nv ? w_new_v : r_flag_v;
    assign w_nz     = w_byp_z  ? w_new_z : r_flag_z;

    // Branch condition decode; every code yields a defined value.
    always_comb begin
        w_br_taken = 1'b0;
        case (bus.br_ccc)
            3'b000:  w_br_taken = ~w_nz;
            3'b001:  w_br_taken = w_nz;
            3'b010:  w_br_taken = ~w_nz & ~w_nn;
            3'b011:  w_br_taken = w_nn;
            3'b100:  w_br_taken = w_nz | (~w_nz & ~w_nn);
            3'b101:  w_br_taken = w_nn | w_nz;
            3'b110:  w_br_taken = w_nv;
            default: w_br_taken = 1'b1;
        endcase
    end

    assign bus.mem_valid  = r_mem_valid;
    assign bus.mem_result = r_mem_result;
    assign bus.flag_n     = r_flag_n;
    assign bus.flag_z     = r_flag_z;
    assign bus.flag_v     = r_flag_v;
    assign bus.br_taken   = w_br_taken;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Scoreboard bench for ex_flag_stage: a bypassing and a non-bypassing instance
// share the same stimulus; expected EX/MEM and flag state is queued per cycle.
module tb_ex_flag_stage;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, XOR = 4'd2, RED = 4'd3,
                           SLL = 4'd4, PADDSB = 4'd7, NOP = 4'd9;

    typedef struct {
        logic        mv;
        logic [15:0] mr;
        logic        n;
        logic        z;
        logic        v;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    exp_t sb_q[$];

    logic        m_n, m_z, m_v, m_mv;
    logic [15:0] m_mr;

    ex_flag_stage_if #(.DW(16)) if_b ();
    ex_flag_stage_if #(.DW(16)) if_c ();

    ex_flag_stage #(.DW(16), .FLAG_BYPASS(1'b1)) u_byp (.clk(clk), .rst_n(rst_n), .bus(if_b));
    ex_flag_stage #(.DW(16), .FLAG_BYPASS(1'b0)) u_nob (.clk(clk), .rst_n(rst_n), .bus(if_c));

    assign if_c.ex_valid  = if_b.ex_valid;
    assign if_c.ex_op     = if_b.ex_op;
    assign if_c.ex_result = if_b.ex_result;
    assign if_c.ex_ovfl   = if_b.ex_ovfl;
    assign if_c.stall     = if_b.stall;
    assign if_c.flush     = if_b.flush;
    assign if_c.br_ccc    = if_b.br_ccc;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic br_ref(input logic [2:0] c, input logic n, input logic z, input logic v);
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic set_in(input logic vl, input logic [3:0] op, input logic [15:0] res,
                          input logic ov, input logic st, input logic fl);
        if_b.ex_valid  = vl;
        if_b.ex_op     = op;
        if_b.ex_result = res;
        if_b.ex_ovfl   = ov;
        if_b.stall     = st;
        if_b.flush     = fl;
    endtask

    // Flags the current EX inputs would write, for the bypass reference.
    task automatic next_flags(output logic nn, output logic nz, output logic nv,
                              output logic wnv, output logic wz, output logic we);
        we  = if_b.ex_valid && !if_b.stall && !if_b.flush;
        wnv = (if_b.ex_op == ADD) || (if_b.ex_op == SUB);
        wz  = wnv || (if_b.ex_op == XOR) || (if_b.ex_op == SLL) ||
              (if_b.ex_op == 4'd5) || (if_b.ex_op == 4'd6);
        nn  = (we && wnv) ? if_b.ex_result[15] : m_n;
        nv  = (we && wnv) ? if_b.ex_ovfl : m_v;
        nz  = (we && wz)  ? (if_b.ex_result == 16'h0) : m_z;
    endtask

    task automatic check_br(input logic [2:0] ccc);
        logic nn, nz, nv, wnv, wz, we;
        if_b.br_ccc = ccc;
        #1;
        next_flags(nn, nz, nv, wnv, wz, we);
        chk($sformatf("br_byp ccc=%0d", ccc), {31'd0, if_b.br_taken}, {31'd0, br_ref(ccc, nn, nz, nv)});
        chk($sformatf("br_nob ccc=%0d", ccc), {31'd0, if_c.br_taken}, {31'd0, br_ref(ccc, m_n, m_z, m_v)});
    endtask

    task automatic check_br_all();
        for (int c = 0; c < 8; c++) check_br(3'(c));
    endtask

    task automatic check_state(input string tag, input exp_t e);
        chk({tag, " mem_valid"},  {31'd0, if_b.mem_valid}, {31'd0, e.mv});
        chk({tag, " mem_result"}, {16'd0, if_b.mem_result}, {16'd0, e.mr});
        chk({tag, " N"}, {31'd0, if_b.flag_n}, {31'd0, e.n});
        chk({tag, " Z"}, {31'd0, if_b.flag_z}, {31'd0, e.z});
        chk({tag, " V"}, {31'd0, if_b.flag_v}, {31'd0, e.v});
        chk({tag, " nob_mem_result"}, {16'd0, if_c.mem_result}, {16'd0, e.mr});
        chk({tag, " nob_NZV"}, {29'd0, if_c.flag_n, if_c.flag_z, if_c.flag_v}, {29'd0, e.n, e.z, e.v});
    endtask

    // One clock: model the edge, queue the expectation, then compare after the edge.
    task automatic step(input string tag);
        logic nn, nz, nv, wnv, wz, we;
        exp_t e;
        next_flags(nn, nz, nv, wnv, wz, we);
        m_n = nn; m_z = nz; m_v = nv;
        if (if_b.flush) m_mv = 1'b0;
        else if (!if_b.stall) begin
            m_mv = if_b.ex_valid;
            if (if_b.ex_valid) m_mr = if_b.ex_result;
        end
        e.mv = m_mv; e.mr = m_mr; e.n = m_n; e.z = m_z; e.v = m_v;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check_state(tag, e);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_z = 0; m_v = 0; m_mv = 0; m_mr = 16'h0;
        sb_q.delete();
    endtask

    initial begin
        exp_t zero;
        tests_run = 0;
        tests_failed = 0;
        zero.mv = 0; zero.mr = 16'h0; zero.n = 0; zero.z = 0; zero.v = 0;
        rst_n = 1'b0;
        if_b.br_ccc = 3'd0;
        set_in(0, NOP, 16'h0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", zero);
        rst_n = 1'b1;

        // ADD giving zero, then SUB saturated negative with overflow.
        set_in(1, ADD, 16'h0000, 0, 0, 0); step("add0");
        chk("add0 Z const", {31'd0, if_b.flag_z}, 32'd1);
        set_in(1, SUB, 16'h8000, 1, 0, 0); step("sub8000");
        chk("sub NZV const", {29'd0, if_b.flag_n, if_b.flag_z, if_b.flag_v}, 32'b101);

        // XOR only writes Z; PADDSB writes nothing.
        set_in(1, XOR, 16'h0000, 0, 0, 0); step("xor0");
        chk("xor NZV const", {29'd0, if_b.flag_n, if_b.flag_z, if_b.flag_v}, 32'b111);
        set_in(1, PADDSB, 16'h1234, 1, 0, 0); step("paddsb");
        chk("paddsb mem const", {16'd0, if_b.mem_result}, 32'h1234);
        set_in(1, RED, 16'h0000, 1, 0, 0); step("red");
        set_in(1, NOP, 16'h0000, 1, 0, 0); step("other_op");

        // Saturated positive overflow: not zero, overflow set.
        set_in(1, ADD, 16'h7FFF, 1, 0, 0); step("sat_pos");
        chk("sat_pos NZV const", {29'd0, if_b.flag_n, if_b.flag_z, if_b.flag_v}, 32'b001);

        // Bubble: valid drops, result holds.
        set_in(0, ADD, 16'h0000, 0, 0, 0); step("bubble");

        // Same-cycle bypass of Z into the branch.
        set_in(1, ADD, 16'h0001, 0, 0, 0); step("z_clear");
        set_in(1, ADD, 16'h0000, 0, 0, 0);
        check_br(3'b001);
        chk("bypass br const", {30'd0, if_b.br_taken, if_c.br_taken}, 32'b10);
        step("bypass_add");

        // All ccc codes against every committed N/Z/V combination, with and without bypass.
        for (int k = 0; k < 8; k++) begin
            logic n, z, v;
            n = k[2]; z = k[1]; v = k[0];
            set_in(1, SUB, n ? 16'h8000 : 16'h0001, v, 0, 0); step("sweep_nv");
            set_in(1, XOR, z ? 16'h0000 : 16'h0003, 0, 0, 0);
            check_br_all();
            step("sweep_z");
            set_in(1, ADD, 16'h4000, !v, 0, 0);
            check_br_all();
            set_in(0, ADD, 16'h0000, 0, 0, 0);
            check_br_all();
            step("sweep_idle");
        end

        // Stall three cycles over a zero-result ADD, then release.
        set_in(1, ADD, 16'h0005, 0, 0, 0); step("pre_stall");
        set_in(1, ADD, 16'h0000, 0, 1, 0);
        check_br(3'b001);
        for (int i = 0; i < 3; i++) step("stall");
        chk("stall Z frozen", {31'd0, if_b.flag_z}, 32'd0);
        chk("stall mem frozen", {16'd0, if_b.mem_result}, 32'h0005);
        set_in(1, ADD, 16'h0000, 0, 0, 0); step("stall_release");
        chk("release Z", {31'd0, if_b.flag_z}, 32'd1);

        // Flush and stall together.
        set_in(1, ADD, 16'h0009, 0, 0, 0); step("pre_flush");
        set_in(1, ADD, 16'h0000, 0, 1, 1);
        check_br(3'b001);
        step("flush_stall");
        chk("flush mem_valid", {31'd0, if_b.mem_valid}, 32'd0);
        set_in(1, SUB, 16'h0000, 1, 0, 1); step("flush_only");

        // Back-to-back writers with random data.
        for (int i = 0; i < 20; i++) begin
            set_in(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   16'($urandom_range(0, 3) == 0 ? 0 : $urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
            check_br(3'($urandom_range(0, 7)));
            step("random");
        end

        // Asynchronous reset in the middle of a cycle with N1 Z0 V1 committed.
        set_in(1, SUB, 16'h8000, 1, 0, 0); step("pre_areset");
        set_in(1, ADD, 16'h0000, 0, 0, 0);
        #4;
        rst_n = 1'b0;
        #1;
        check_state("async_reset", zero);
        model_reset();
        set_in(0, NOP, 16'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_in(1, SUB, 16'hFFFF, 0, 0, 0); step("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ex_flag_stage.md
Name: ex_flag_stage

Overview:
- Sits directly downstream of the 16-bit saturating add/sub unit in the execute stage.
- Captures the EX result into the EX/MEM boundary register.
- Maintains the architectural N/Z/V flag register with per-opcode update rules.
- Evaluates the 3-bit branch condition for the decode stage, with same-cycle flag bypass from the instruction currently in EX.

Parameters:
- DW, 16, datapath width of result.
- FLAG_BYPASS, 1, 1 = branch evaluation sees flags being written by the current EX instruction; 0 = committed flags only.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX holds a live instruction
- ex_op  in  4  EX opcode: 0000 ADD, 0001 SUB, 0010 XOR, 0011 RED, 0100 SLL, 0101 SRA, 0110 ROR, 0111 PADDSB, others = no flag effect
- ex_result  in  DW  final (saturated) ALU result
- ex_ovfl  in  1  overflow from adder, valid for ADD/SUB
- stall  in  1  hold EX/MEM register and flags
- flush  in  1  kill the EX instruction
- br_ccc  in  3  condition code of the branch in decode
- mem_valid  out  1  registered valid
- mem_result  out  DW  registered result
- flag_n  out  1  committed N
- flag_z  out  1  committed Z
- flag_v  out  1  committed V
- br_taken  out  1  combinational condition result

Behaviour:
- Reset (async, rst_n=0): mem_valid=0, mem_result=0, flag_n=0, flag_z=0, flag_v=0, held while rst_n low. Release takes effect at the next clk edge. Reset mid-stream discards any pending result.
- Write enable: we = ex_valid & ~stall & ~flush.
- Flag write classes:
  - ADD/SUB: write N=ex_result[DW-1], Z=(ex_result==0), V=ex_ovfl.
  - XOR/SLL/SRA/ROR: write Z only; N and V hold.
  - RED/PADDSB/other opcodes: no flag change.
- Flags update on the rising edge when we=1, so flags are visible one cycle after the instruction leaves EX. Z is computed on the saturated result, e.g. 0x7FFF + 0x0001 gives Z=0, V=1, N=0.
- EX/MEM register priority, highest first:
  - flush: mem_valid<=0; mem_result holds its old value.
  - stall: mem_valid and mem_result hold.
  - else: mem_valid<=ex_valid; mem_result<=ex_result when ex_valid=1, otherwise mem_result holds.
- Latency: exactly 1 cycle from EX to mem_result.
- Flags are never modified when stall=1 or flush=1, including when both are 1.
- Next-flag values for the branch compare (nN, nZ, nV):
  - FLAG_BYPASS=1 and we=1: each flag the EX opcode writes takes its new value; the others use the committed value.
  - Otherwise: committed values.
- br_taken by br_ccc:
  - 000: ~nZ
  - 001: nZ
  - 010: ~nZ & ~nN
  - 011: nN
  - 100: nZ | (~nZ & ~nN)
  - 101: nN | nZ
  - 110: nV
  - 111: 1
- br_taken is purely combinational, with no dependence on mem_*.
- Back-to-back flag writers: each cycle's write replaces the previous one. Ordering is preserved because only one instruction is in EX per cycle.
- No X propagation: br_taken is defined for all inputs once out of reset.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle after flags = N1 Z0 V1 -> all outputs 0 immediately, without waiting for a clock edge.
- ADD with ex_result=0x0000, ex_ovfl=0, then SUB with ex_result=0x8000, ex_ovfl=1 -> after cycle 1 Z=1 N=0 V=0; after cycle 2 Z=0 N=1 V=1; mem_result tracks with 1-cycle latency.
- Set N=1 V=1 via SUB, then XOR with result 0 -> Z=1, N=1 and V=1 retained. Then PADDSB with result 0x1234 -> flags unchanged, mem_result=0x1234.
- Bypass: committed Z=0, EX ADD with result 0, br_ccc=001 same cycle -> br_taken=1 with FLAG_BYPASS=1, br_taken=0 with FLAG_BYPASS=0. Sweep all 8 ccc codes over all N/Z/V combinations against the table.
- Stall 3 cycles with ex_valid=1 ADD result 0 -> flags and mem_* frozen. Release -> update on the next edge.
- Flush and stall together on an ADD (result 0x0000) -> flags unchanged, mem_valid=0 next cycle, mem_result unchanged.
